// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage 16-bit pipeline hazard logic.
package pipe_pkg;

  localparam int unsigned REG_W       = 3;
  localparam int unsigned INSTR_W     = 16;
  localparam int unsigned RS_HI       = 12;
  localparam int unsigned RS_LO       = 10;
  localparam int unsigned RT_HI       = 9;
  localparam int unsigned RT_LO       = 7;
  localparam int unsigned STALL_CNT_W = 3;
  localparam int unsigned PERF_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // One in-flight register writer (RegWrite plus destination).
  typedef struct packed {
    logic             we;
    logic [REG_W-1:0] rd;
  } writer_t;

  // Stall counter increment that holds at all-ones.
  function automatic logic [STALL_CNT_W-1:0] stall_sat_inc(input logic [STALL_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/hazard_compare.sv
// Combinational RAW detector: IF/ID sources against the in-flight writers.
module hazard_compare
  import pipe_pkg::*;
#(
  parameter bit WB_BYPASS    = 1'b0,
  parameter bit R0_HARDWIRED = 1'b1
) (
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  writer_t          id_wr,
  input  writer_t          ex_wr,
  input  writer_t          mem_wr,
  output logic             hz_c
);

  // A writer hits a source when it writes that register and r0 is not masked.
  function automatic logic src_hit(input logic [REG_W-1:0] src, input writer_t w);
    return w.we && (src == w.rd) && !(R0_HARDWIRED && (src == '0));
  endfunction

  logic id_hit, ex_hit, mem_hit;

  // Both sources are compared for every opcode; false stalls are tolerated.
  always_comb begin
    id_hit  = src_hit(rs, id_wr)  || src_hit(rt, id_wr);
    ex_hit  = src_hit(rs, ex_wr)  || src_hit(rt, ex_wr);
    mem_hit = !WB_BYPASS && (src_hit(rs, mem_wr) || src_hit(rt, mem_wr));
    hz_c    = id_hit || ex_hit || mem_hit;
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: RAW stalls with ID/EX bubbles and taken-branch flushes.
// Optional HAZARD_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_controller
  import pipe_pkg::*;
#(
  parameter bit          WB_BYPASS    = 1'b0,
  parameter bit          R0_HARDWIRED = 1'b1,
  parameter int unsigned MAX_STALL    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [INSTR_W-1:0]    i_Instruction,
  input  logic                  i_Id_Sig_RegWrite,
  input  logic [REG_W-1:0]      i_Id_Write_Register,
  input  logic                  i_Ex_Sig_RegWrite,
  input  logic [REG_W-1:0]      i_Ex_Write_Register,
  input  logic                  i_Mem_Sig_RegWrite,
  input  logic [REG_W-1:0]      i_Mem_Write_Register,
  input  logic                  i_Branch_Taken,
  output logic                  o_Pc_Write,
  output logic                  o_If_Id_Write,
  output logic                  o_Id_Ex_Bubble,
  output logic                  o_If_Id_Flush,
  output logic                  o_Id_Ex_Flush,
  output logic                  o_Ex_Mem_Flush,
  output logic [1:0]            o_State,
`ifdef HAZARD_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] o_Stall_Count,
  output logic [PERF_CNT_W-1:0] o_Flush_Count,
`endif
  output logic                  o_Err
);

  state_t                 state, state_nxt;
  logic [STALL_CNT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic                   err_set;
  logic                   hz;
  logic [REG_W-1:0]       rs, rt;
  writer_t                id_wr, ex_wr, mem_wr;
  logic                   unused_instr_bits;

  assign rs     = i_Instruction[RS_HI:RS_LO];
  assign rt     = i_Instruction[RT_HI:RT_LO];
  assign id_wr  = '{we: i_Id_Sig_RegWrite,  rd: i_Id_Write_Register};
  assign ex_wr  = '{we: i_Ex_Sig_RegWrite,  rd: i_Ex_Write_Register};
  assign mem_wr = '{we: i_Mem_Sig_RegWrite, rd: i_Mem_Write_Register};
  assign unused_instr_bits = ^{i_Instruction[INSTR_W-1:RS_HI+1], i_Instruction[RT_LO-1:0]};

  hazard_compare #(
    .WB_BYPASS    (WB_BYPASS),
    .R0_HARDWIRED (R0_HARDWIRED)
  ) u_compare (
    .rs     (rs),
    .rt     (rt),
    .id_wr  (id_wr),
    .ex_wr  (ex_wr),
    .mem_wr (mem_wr),
    .hz_c   (hz)
  );

  // Next state, stall count and Mealy pipeline controls; reset > branch > hazard.
  always_comb begin
    state_nxt      = ST_RUN;
    stall_cnt_nxt  = '0;
    o_Pc_Write     = 1'b1;
    o_If_Id_Write  = 1'b1;
    o_Id_Ex_Bubble = 1'b0;
    o_If_Id_Flush  = 1'b0;
    o_Id_Ex_Flush  = 1'b0;
    o_Ex_Mem_Flush = 1'b0;
    if (reset) begin
      o_Pc_Write     = 1'b0;
      o_If_Id_Write  = 1'b0;
      o_If_Id_Flush  = 1'b1;
      o_Id_Ex_Flush  = 1'b1;
      o_Ex_Mem_Flush = 1'b1;
    end else if (i_Branch_Taken) begin
      state_nxt      = ST_FLUSH;
      o_If_Id_Flush  = 1'b1;
      o_Id_Ex_Flush  = 1'b1;
      o_Ex_Mem_Flush = 1'b1;
    end else if (hz) begin
      state_nxt      = ST_STALL;
      o_Pc_Write     = 1'b0;
      o_If_Id_Write  = 1'b0;
      o_Id_Ex_Bubble = 1'b1;
      unique case (state)
        ST_STALL: stall_cnt_nxt = stall_sat_inc(stall_cnt);
        default:  stall_cnt_nxt = STALL_CNT_W'(1);
      endcase
    end
    err_set = (32'(stall_cnt_nxt) > MAX_STALL);
  end

  // State, stall counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      stall_cnt <= '0;
      o_Err     <= 1'b0;
    end else begin
      state     <= state_nxt;
      stall_cnt <= stall_cnt_nxt;
      o_Err     <= o_Err | err_set;
    end
  end

  assign o_State = state;

`ifdef HAZARD_PERF_CNT_EN
  logic stall_act, flush_act;

  assign stall_act = !reset && !i_Branch_Taken && hz;
  assign flush_act = !reset && i_Branch_Taken;

  // Saturating counts of stall cycles and taken-branch cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_Stall_Count <= '0;
      o_Flush_Count <= '0;
    end else begin
      if (stall_act && (o_Stall_Count != '1)) o_Stall_Count <= o_Stall_Count + PERF_CNT_W'(1);
      if (flush_act && (o_Flush_Count != '1)) o_Flush_Count <= o_Flush_Count + PERF_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: one instance per WB_BYPASS setting.
module tb_hazard_controller;

  typedef struct packed {
    logic [5:0]  ctl;   // {pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, ex_mem_flush}
    logic [1:0]  st;
    logic        err;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        id_we, ex_we, mem_we, taken;
  logic [2:0]  id_rd, ex_rd, mem_rd;

  logic [1:0]  pc_write, if_id_write, bubble, if_id_flush, id_ex_flush, ex_mem_flush, err;
  logic [1:0]  st [2];
  logic [15:0] stall_count [2];
  logic [15:0] flush_count [2];

  exp_t sb0[$], sb1[$];
  exp_t e0, e1;

  int n_checks = 0;
  int n_errors = 0;
  int stalls_seen [2];

  // Reference model state, one slot per instance.
  logic [1:0]  m_state [2];
  int          m_cnt   [2];
  logic        m_err   [2];
  logic [15:0] m_sc    [2];
  logic [15:0] m_fc    [2];
  logic        hz_cur  [2];

  always #5 clk = ~clk;

  hazard_controller #(.WB_BYPASS(1'b0), .R0_HARDWIRED(1'b1), .MAX_STALL(3)) dut0 (
    .clk(clk), .reset(reset), .i_Instruction(instr),
    .i_Id_Sig_RegWrite(id_we), .i_Id_Write_Register(id_rd),
    .i_Ex_Sig_RegWrite(ex_we), .i_Ex_Write_Register(ex_rd),
    .i_Mem_Sig_RegWrite(mem_we), .i_Mem_Write_Register(mem_rd),
    .i_Branch_Taken(taken),
    .o_Pc_Write(pc_write[0]), .o_If_Id_Write(if_id_write[0]), .o_Id_Ex_Bubble(bubble[0]),
    .o_If_Id_Flush(if_id_flush[0]), .o_Id_Ex_Flush(id_ex_flush[0]), .o_Ex_Mem_Flush(ex_mem_flush[0]),
    .o_State(st[0]),
`ifdef HAZARD_PERF_CNT_EN
    .o_Stall_Count(stall_count[0]), .o_Flush_Count(flush_count[0]),
`endif
    .o_Err(err[0])
  );

  hazard_controller #(.WB_BYPASS(1'b1), .R0_HARDWIRED(1'b1), .MAX_STALL(3)) dut1 (
    .clk(clk), .reset(reset), .i_Instruction(instr),
    .i_Id_Sig_RegWrite(id_we), .i_Id_Write_Register(id_rd),
    .i_Ex_Sig_RegWrite(ex_we), .i_Ex_Write_Register(ex_rd),
    .i_Mem_Sig_RegWrite(mem_we), .i_Mem_Write_Register(mem_rd),
    .i_Branch_Taken(taken),
    .o_Pc_Write(pc_write[1]), .o_If_Id_Write(if_id_write[1]), .o_Id_Ex_Bubble(bubble[1]),
    .o_If_Id_Flush(if_id_flush[1]), .o_Id_Ex_Flush(id_ex_flush[1]), .o_Ex_Mem_Flush(ex_mem_flush[1]),
    .o_State(st[1]),
`ifdef HAZARD_PERF_CNT_EN
    .o_Stall_Count(stall_count[1]), .o_Flush_Count(flush_count[1]),
`endif
    .o_Err(err[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [2:0] rs, input logic [2:0] rt);
    return {3'b101, rs, rt, 7'h15};
  endfunction

  function automatic logic hz_ref(input logic bypass);
    logic [15:0] t;
    logic [2:0]  rs, rt;
    logic        h;
    t  = instr;
    rs = t[12:10];
    rt = t[9:7];
    h  = 1'b0;
    if (id_we && id_rd != 3'd0 && (id_rd == rs || id_rd == rt)) h = 1'b1;
    if (ex_we && ex_rd != 3'd0 && (ex_rd == rs || ex_rd == rt)) h = 1'b1;
    if (!bypass && mem_we && mem_rd != 3'd0 && (mem_rd == rs || mem_rd == rt)) h = 1'b1;
    return h;
  endfunction

  task automatic set_in(input logic [15:0] i, input logic iw, input logic [2:0] ir,
                        input logic ew, input logic [2:0] er,
                        input logic mw, input logic [2:0] mr, input logic tk);
    instr = i; id_we = iw; id_rd = ir; ex_we = ew; ex_rd = er;
    mem_we = mw; mem_rd = mr; taken = tk;
  endtask

  // Push the expected outputs for the current inputs, then advance the model one edge.
  task automatic step();
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      hz_cur[d] = hz_ref(d == 1);
      if (reset)              e.ctl = 6'b000111;
      else if (taken)         e.ctl = 6'b110111;
      else if (hz_cur[d])     e.ctl = 6'b001000;
      else                    e.ctl = 6'b110000;
      e.st  = m_state[d];
      e.err = m_err[d];
      e.sc  = m_sc[d];
      e.fc  = m_fc[d];
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        m_state[d] = 2'd0; m_cnt[d] = 0; m_err[d] = 1'b0; m_sc[d] = '0; m_fc[d] = '0;
      end else if (taken) begin
        m_state[d] = 2'd2; m_cnt[d] = 0;
        if (m_fc[d] != 16'hFFFF) m_fc[d]++;
      end else if (hz_cur[d]) begin
        if (m_state[d] == 2'd1) begin
          if (m_cnt[d] < 7) m_cnt[d]++;
        end else begin
          m_cnt[d] = 1;
        end
        m_state[d] = 2'd1;
        if (m_cnt[d] > 3) m_err[d] = 1'b1;
        if (m_sc[d] != 16'hFFFF) m_sc[d]++;
      end else begin
        m_state[d] = 2'd0; m_cnt[d] = 0;
      end
    end
    #1;
  endtask

  task automatic cmp_dut(input int d, input exp_t e);
    logic [5:0] ctl;
    ctl = {pc_write[d], if_id_write[d], bubble[d], if_id_flush[d], id_ex_flush[d], ex_mem_flush[d]};
    check_eq($sformatf("dut%0d ctl", d), 32'(ctl), 32'(e.ctl));
    check_eq($sformatf("dut%0d state", d), 32'(st[d]), 32'(e.st));
    check_eq($sformatf("dut%0d err", d), 32'(err[d]), 32'(e.err));
`ifdef HAZARD_PERF_CNT_EN
    check_eq($sformatf("dut%0d stall_count", d), 32'(stall_count[d]), 32'(e.sc));
    check_eq($sformatf("dut%0d flush_count", d), 32'(flush_count[d]), 32'(e.fc));
`endif
  endtask

  // Output monitor: pop one expectation per instance away from the active edge.
  always @(negedge clk) begin
    if (sb0.size() != 0) begin
      e0 = sb0.pop_front();
      cmp_dut(0, e0);
      if (bubble[0] === 1'b1) stalls_seen[0]++;
    end
    if (sb1.size() != 0) begin
      e1 = sb1.pop_front();
      cmp_dut(1, e1);
      if (bubble[1] === 1'b1) stalls_seen[1]++;
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_state[d] = 2'd0; m_cnt[d] = 0; m_err[d] = 1'b0; m_sc[d] = '0; m_fc[d] = '0;
      stalls_seen[d] = 0;
    end
    reset = 1'b1;
    set_in(16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    @(posedge clk); #1;
    step();
    step();
    reset = 1'b0;
    step();

    // Back-to-back RAW on r1: 3 stalls without bypass, 2 with.
    stalls_seen[0] = 0; stalls_seen[1] = 0;
    set_in(mk(3'd1, 3'd3), 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
    set_in(mk(3'd1, 3'd3), 1'b0, 3'd0, 1'b1, 3'd1, 1'b0, 3'd0, 1'b0); step();
    set_in(mk(3'd1, 3'd3), 1'b0, 3'd0, 1'b0, 3'd0, 1'b1, 3'd1, 1'b0); step();
    set_in(mk(3'd1, 3'd3), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
    set_in(mk(3'd4, 3'd5), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
    check_eq("raw stalls wb0", 32'(stalls_seen[0]), 32'd3);
    check_eq("raw stalls wb1", 32'(stalls_seen[1]), 32'd2);

    // Writers to r0 never stall a reader of r0.
    stalls_seen[0] = 0; stalls_seen[1] = 0;
    set_in(mk(3'd0, 3'd0), 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0); step();
    set_in(mk(3'd0, 3'd6), 1'b1, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 1'b0); step();
    check_eq("r0 no stall", 32'(stalls_seen[0] + stalls_seen[1]), 32'd0);

    // Hazard and taken branch together: flush wins, FLUSH for one cycle.
    set_in(mk(3'd2, 3'd6), 1'b1, 3'd6, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1); step();
    set_in(mk(3'd2, 3'd4), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
    step();

    // Reset during the second stall cycle.
    set_in(mk(3'd3, 3'd1), 1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();
    set_in(mk(3'd3, 3'd1), 1'b0, 3'd0, 1'b1, 3'd3, 1'b0, 3'd0, 1'b0);
    reset = 1'b1; step();
    reset = 1'b0;
    set_in(mk(3'd3, 3'd1), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0); step();

    // Random traffic against the reference model.
    for (int n = 0; n < 200; n++) begin
      set_in(16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom),
             1'($urandom), 3'($urandom), ($urandom_range(0, 7) == 0));
      reset = ($urandom_range(0, 39) == 0);
      step();
    end

    // Clean reset, then a 5-cycle forced hazard to trip the stall error.
    reset = 1'b1;
    set_in(16'h0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step(); step();
    reset = 1'b0;
    step();
    stalls_seen[0] = 0; stalls_seen[1] = 0;
    set_in(mk(3'd1, 3'd1), 1'b1, 3'd1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    for (int n = 0; n < 5; n++) step();
    set_in(mk(3'd1, 3'd1), 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    step(); step();
    check_eq("long stall cycles", 32'(stalls_seen[0]), 32'd5);
    check_eq("err sticky wb0", 32'(err[0]), 32'd1);
    check_eq("err sticky wb1", 32'(err[1]), 32'd1);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_count after 5", 32'(stall_count[0]), 32'd5);
`endif
    check_eq("scoreboard drained", 32'(sb0.size() + sb1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
